mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; only 32 is supported.
REQ-002 The block SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clear  input  1  reset; synchronous, active-low (0 = reset).
REQ-004 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 The block SHALL have port op  input  1  operation select; 0 = MUL, 1 = DIV; sampled with start.
REQ-006 The block SHALL have port a  input  32  signed operand A (Y register); multiplicand or dividend.
REQ-007 The block SHALL have port b  input  32  signed operand B (BusMuxOut); multiplier or divisor.
REQ-008 The block SHALL have port busy  output  1  operation in progress.
REQ-009 The block SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 The block SHALL have port zhigh  output  32  high result word, feeding Z-high register input.
REQ-011 The block SHALL have port zlow  output  32  low result word, feeding Z-low register input.
REQ-012 The block SHALL have port div_by_zero  output  1  sticky flag for the last DIV with b = 0.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, FIXUP and DONE.
REQ-014 In IDLE with start = 1, the block SHALL latch a, b and op, clear the iteration counter and go to RUN.
REQ-015 The block SHALL stay in RUN for exactly 32 cycles, one radix-2 iteration per cycle, then go to FIXUP.
- MUL: Booth recoding.
- DIV: non-restoring on operand magnitudes.
REQ-016 FIXUP SHALL last 1 cycle (sign correction, remainder restore), then go to DONE.
REQ-017 DONE SHALL last 1 cycle with done = 1, then go to IDLE.
REQ-018 done SHALL assert exactly 34 rising edges after the edge that sampled start.
REQ-019 busy SHALL be 1 in RUN and FIXUP and 0 in IDLE and DONE.
REQ-020 MUL SHALL produce {zhigh,zlow} = full signed 64-bit product a*b, exact with no overflow.
REQ-021 DIV SHALL produce zlow = quotient truncated toward zero and zhigh = remainder carrying the sign of the dividend.
REQ-022 DIV with a = 0x80000000 and b = 0xFFFFFFFF SHALL give zlow = 0x80000000 (wrap) and zhigh = 0.
REQ-023 DIV with b = 0 SHALL keep full 34-cycle latency and give zlow = 0xFFFFFFFF, zhigh = a, div_by_zero = 1.
REQ-024 div_by_zero SHALL be cleared when the next start is accepted and set only per REQ-023.
REQ-025 zhigh and zlow SHALL change only in the DONE transition and hold their value until the next DONE.
REQ-026 start in RUN, FIXUP or DONE SHALL be ignored, with no queuing.
REQ-027 start in the IDLE cycle immediately after DONE SHALL be accepted, giving back-to-back ops at a 35-cycle cadence.
REQ-028 Changes on a, b or op after start is accepted SHALL have no effect on the running operation.

Reset
REQ-029 On a rising edge with clear = 0, the block SHALL enter IDLE and set busy = 0, done = 0, zhigh = 0, zlow = 0, div_by_zero = 0, counter = 0.
REQ-030 clear = 0 in any state, including mid-RUN, SHALL abort the operation with no done pulse; the block SHALL accept start on the first edge with clear = 1.
REQ-031 clear SHALL take priority over start on the same edge.

Verification
REQ-032 MUL a = 0xFFFFFFFA (-6), b = 7 -> done at edge +34; zhigh = 0xFFFFFFFF, zlow = 0xFFFFFFD6 (-42).
REQ-033 MUL a = 0x80000000, b = 0x80000000 -> zhigh = 0x40000000, zlow = 0x00000000.
REQ-034 DIV a = 0xFFFFFFF9 (-7), b = 2 -> zlow = 0xFFFFFFFD (-3), zhigh = 0xFFFFFFFF (-1), div_by_zero = 0.
REQ-035 DIV a = 25, b = 0 -> done at +34; zlow = 0xFFFFFFFF, zhigh = 25, div_by_zero = 1; a following MUL 3*4 clears the flag and gives zlow = 12.
REQ-036 Start MUL 5*5, pulse clear = 0 at cycle 10, then start DIV 100/7 -> no done for the MUL; DIV gives zlow = 14, zhigh = 2.
REQ-037 start held high continuously with alternating operands -> done every 35 cycles; busy = 0 exactly on DONE and IDLE cycles; mid-RUN start ignored.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit signed multiply / divide unit: radix-2 Booth multiply and
// non-restoring divide on magnitudes, 34-cycle latency from start to done.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] zhigh,
    output logic [WIDTH-1:0] zlow,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic              op_q;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic [WIDTH-1:0]  a_q;
    logic [RW-1:0]     m_q;
    logic [RW-1:0]     acc;
    logic [WIDTH-1:0]  qr;
    logic              qm1;

    logic [RW-1:0]     sum;
    logic [RW-1:0]     shifted;
    logic [RW-1:0]     acc_nx;
    logic [WIDTH-1:0]  qr_nx;
    logic              qm1_nx;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  q_fix;
    logic [WIDTH-1:0]  r_fix;
    logic [WIDTH-1:0]  hi_fix;
    logic [WIDTH-1:0]  lo_fix;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track the FSM exactly
    always_ff @(posedge clock) begin
        if (!clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx == RUN) || (state_nx == FIXUP);
            done <= (state_nx == DONE);
        end
    end

    // One radix-2 step: Booth add/sub + arithmetic shift, or non-restoring shift + add/sub
    always_comb begin
        sum     = '0;
        shifted = '0;
        acc_nx  = acc;
        qr_nx   = qr;
        qm1_nx  = qm1;
        if (op_q) begin
            shifted = {acc[RW-2:0], qr[WIDTH-1]};
            sum     = acc[RW-1] ? (shifted + m_q) : (shifted - m_q);
            acc_nx  = sum;
            qr_nx   = {qr[WIDTH-2:0], ~sum[RW-1]};
        end else begin
            case ({qr[0], qm1})
                2'b01:   sum = acc + m_q;
                2'b10:   sum = acc - m_q;
                default: sum = acc;
            endcase
            acc_nx = {sum[RW-1], sum[RW-1:1]};
            qr_nx  = {sum[0], qr[WIDTH-1:1]};
            qm1_nx = qr[0];
        end
    end

    // Final correction: remainder restore, sign fix, divide-by-zero override
    always_comb begin
        rem    = acc[RW-1] ? WIDTH'(acc + m_q) : acc[WIDTH-1:0];
        q_fix  = (a_neg ^ b_neg) ? -qr : qr;
        r_fix  = a_neg ? -rem : rem;
        hi_fix = acc[WIDTH-1:0];
        lo_fix = qr;
        if (op_q) begin
            if (b_zero) begin
                hi_fix = a_q;
                lo_fix = '1;
            end else begin
                hi_fix = r_fix;
                lo_fix = q_fix;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (!clear) begin
            cnt         <= '0;
            op_q        <= 1'b0;
            a_neg       <= 1'b0;
            b_neg       <= 1'b0;
            b_zero      <= 1'b0;
            a_q         <= '0;
            m_q         <= '0;
            acc         <= '0;
            qr          <= '0;
            qm1         <= 1'b0;
            zhigh       <= '0;
            zlow        <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        op_q        <= op;
                        a_neg       <= a[WIDTH-1];
                        b_neg       <= b[WIDTH-1];
                        b_zero      <= (b == '0);
                        a_q         <= a;
                        acc         <= '0;
                        qm1         <= 1'b0;
                        div_by_zero <= 1'b0;
                        if (op) begin
                            qr  <= mag(a);
                            m_q <= {{(RW - WIDTH){1'b0}}, mag(b)};
                        end else begin
                            qr  <= b;
                            m_q <= {{(RW - WIDTH){a[WIDTH-1]}}, a};
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nx;
                    qr  <= qr_nx;
                    qm1 <= qm1_nx;
                    cnt <= cnt + CW'(1);
                end
                FIXUP: begin
                    zhigh <= hi_fix;
                    zlow  <= lo_fix;
                    if (op_q && b_zero) begin
                        div_by_zero <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a timeline/arithmetic reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_mul_div_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] zhigh;
    logic [31:0] zlow;
    logic        div_by_zero;

    always #5 clock = ~clock;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .zhigh       (zhigh),
        .zlow        (zlow),
        .div_by_zero (div_by_zero)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          ph = -1;          // edges since accepted start, -1 when idle
    bit          rst_seen = 1'b0;
    logic        l_op;
    logic [31:0] l_a;
    logic [31:0] l_b;
    logic [31:0] e_hi = '0;
    logic [31:0] e_lo = '0;
    logic        e_dbz = 1'b0;
    int          done_cnt = 0;
    int          done_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference results from plain signed arithmetic
    task automatic model_result(input logic o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        int     sx;
        int     sy;
        sx = $signed(x);
        sy = $signed(y);
        if (!o) begin
            p  = longint'(sx) * longint'(sy);
            hi = p[63:32];
            lo = p[31:0];
        end else if (y == 32'h0) begin
            hi = x;
            lo = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            hi = 32'h0;
            lo = 32'h8000_0000;
        end else begin
            lo = 32'(sx / sy);
            hi = 32'(sx % sy);
        end
    endtask

    // Model timeline: accept in idle, results appear 33 edges later, idle again at 34
    always @(posedge clock) begin
        cyc++;
        if (!clear) begin
            ph       = -1;
            e_hi     = '0;
            e_lo     = '0;
            e_dbz    = 1'b0;
            rst_seen = 1'b1;
        end else if (ph < 0) begin
            if (start) begin
                ph    = 0;
                l_op  = op;
                l_a   = a;
                l_b   = b;
                e_dbz = 1'b0;
            end
        end else begin
            ph++;
            if (ph == 33) begin
                model_result(l_op, l_a, l_b, e_hi, e_lo);
                if (l_op && l_b == 32'h0) e_dbz = 1'b1;
            end else if (ph == 34) begin
                ph = -1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (rst_seen) begin
            chk("busy", 64'(busy), 64'(ph >= 0 && ph <= 32));
            chk("done", 64'(done), 64'(ph == 33));
            chk("zhigh", 64'(zhigh), 64'(e_hi));
            chk("zlow", 64'(zlow), 64'(e_lo));
            chk("div_by_zero", 64'(div_by_zero), 64'(e_dbz));
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
    end

    // Called at a negedge with the block idle; returns at the idle negedge after done
    task automatic run_op(input string nm, input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        int n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clock);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = y + 32'd3;
        n     = 1;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'd34);
        chk({nm, " zhigh"}, 64'(zhigh), 64'(hi));
        chk({nm, " zlow"}, 64'(zlow), 64'(lo));
        chk({nm, " dbz"}, 64'(div_by_zero), 64'(dz));
        @(negedge clock);
    endtask

    initial begin
        int d0;
        clear = 1'b0;
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd5;
        b     = 32'd0;
        repeat (3) @(negedge clock);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset zhigh", 64'(zhigh), 64'd0);
        chk("reset zlow", 64'(zlow), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        clear = 1'b1;
        start = 1'b0;
        @(negedge clock);

        run_op("mul -6*7", 1'b0, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("mul min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("mul -1*min", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div 100/-7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run_op("div -100/7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("div 25/0", 1'b1, 32'd25, 32'd0, 32'd25, 32'hFFFF_FFFF, 1'b1);
        chk("dbz sticky", 64'(div_by_zero), 64'd1);
        run_op("mul 3*4", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);

        // Abort a multiply mid-run, then divide on the first edge out of reset
        d0    = done_cnt;
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        chk("abort busy", 64'(busy), 64'd0);
        clear = 1'b1;
        run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        chk("abort done count", 64'(done_cnt - d0), 64'd1);

        // Start held high with operands changing every cycle
        done_cyc.delete();
        start = 1'b1;
        for (int i = 0; i < 110; i++) begin
            op = i[0];
            a  = 32'(i * 37 - 900);
            b  = (i % 7 == 0) ? 32'd0 : 32'(i - 50);
            @(negedge clock);
        end
        start = 1'b0;
        chk("held done pulses", 64'(done_cyc.size() >= 3), 64'd1);
        for (int i = 1; i < done_cyc.size(); i++) begin
            chk("held cadence", 64'(done_cyc[i] - done_cyc[i-1]), 64'd35);
        end
        repeat (40) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
